// File: rtl/cnn_mux_pkg.sv
// rtl/cnn_mux_pkg.sv - shared types and helpers for the CNN stream multiplexer
// Purpose: FSM state encoding, mode encoding and a clog2 helper used to size
//          channel-index ports.
// Ports:   none (package).
package cnn_mux_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  // Width needed to index n items; n >= 2 is assumed by all users.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnn_rr_arb.sv
// rtl/cnn_rr_arb.sv - combinational round-robin priority search
// Purpose: pick the first requesting channel after rr_ptr, wrapping modulo N_CH.
// Ports:
//   req       in   N_CH   request vector
//   rr_ptr    in   SEL_W  last channel served; search starts at rr_ptr+1
//   gnt_valid out  1      at least one request present
//   gnt_idx   out  SEL_W  chosen channel (0 when gnt_valid=0)
module cnn_rr_arb
  import cnn_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // Each channel's distance from rr_ptr+1 in the circular order; the
  // requesting channel with the smallest distance wins.
  always_comb begin
    int d;
    int best;
    best    = N_CH;
    gnt_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      d = k - int'(rr_ptr) - 1;
      if (d < 0) d = d + N_CH;
      if (req[k] && (d < best)) begin
        best    = d;
        gnt_idx = SEL_W'(k);
      end
    end
    gnt_valid = (best < N_CH);
  end

endmodule

// File: rtl/cnn_stream_mux.sv
// rtl/cnn_stream_mux.sv - registered N:1 packet multiplexer with sel or round-robin arbitration
// Purpose: forward whole packets from one of N_CH valid/ready input channels to a
//          single registered output; a granted channel keeps the output until its
//          last beat is accepted.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   mode, sel                0 = use sel, 1 = round-robin (sampled in IDLE only)
//   in_valid/in_data/in_last per-channel input stream, channel k at [k*DATA_W +: DATA_W]
//   in_ready                 per-channel accept (combinational)
//   out_valid/out_data/out_last/out_ch  registered output beat and its source channel
//   out_ready                downstream accept
module cnn_stream_mux
  import cnn_mux_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int N_CH   = 4,
  localparam int SEL_W  = clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_ch,
  input  logic                   out_ready
);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               mode_q, mode_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  logic [SEL_W-1:0]   out_ch_q, out_ch_d;

  logic               arb_valid;
  logic [SEL_W-1:0]   arb_idx;
  logic               sel_hit;
  logic               g_valid;
  logic               g_last;
  logic [DATA_W-1:0]  g_data;
  logic               out_free;
  logic               beat_acc;

  cnn_rr_arb #(.N_CH(N_CH)) u_arb (
    .req       (in_valid),
    .rr_ptr    (rr_ptr_q),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Channel selection by comparison rather than indexing, so an out-of-range
  // sel (N_CH not a power of two) simply never matches.
  always_comb begin
    sel_hit = 1'b0;
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if ((sel == SEL_W'(k)) && in_valid[k]) sel_hit = 1'b1;
      if (grant_q == SEL_W'(k)) begin
        g_valid = in_valid[k];
        g_last  = in_last[k];
        g_data  = in_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign out_free = !out_valid_q || out_ready;
  assign beat_acc = (state_q == ST_BUSY) && g_valid && out_free;

  always_comb begin
    in_ready = '0;
    if ((state_q == ST_BUSY) && out_free) begin
      for (int k = 0; k < N_CH; k++) begin
        if (grant_q == SEL_W'(k)) in_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    mode_d      = mode_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;

    case (state_q)
      ST_IDLE: begin
        if (mode == MODE_RR) begin
          if (arb_valid) begin
            grant_d = arb_idx;
            mode_d  = MODE_RR;
            state_d = ST_BUSY;
          end
        end else if (sel_hit) begin
          grant_d = sel;
          mode_d  = MODE_SEL;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (beat_acc && g_last) begin
          state_d = ST_IDLE;
          // Only round-robin packets advance the fairness pointer.
          if (mode_q == MODE_RR) rr_ptr_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Output register also drains in IDLE, so the last beat of a packet
    // leaves while the next arbitration happens.
    if (beat_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = g_data;
      out_last_d  = g_last;
      out_ch_d    = grant_q;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= SEL_W'(N_CH - 1);
      mode_q      <= MODE_SEL;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_cnn_stream_mux.sv
// tb/tb_cnn_stream_mux.sv - self-checking bench for cnn_stream_mux
module tb_cnn_stream_mux;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         mode;
  logic [1:0]   sel;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [3:0]   in_last;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_last;
  logic [1:0]   out_ch;
  logic         out_ready;

  logic         mode3;
  logic [1:0]   sel3;
  logic [2:0]   in_valid3;
  logic [23:0]  in_data3;
  logic [2:0]   in_last3;
  logic [2:0]   in_ready3;
  logic         out_valid3;
  logic [7:0]   out_data3;
  logic         out_last3;
  logic [1:0]   out_ch3;
  logic         out_ready3;

  cnn_stream_mux #(.DATA_W(32), .N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
    .out_ready(out_ready)
  );

  cnn_stream_mux #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_valid(in_valid3), .in_data(in_data3), .in_last(in_last3), .in_ready(in_ready3),
    .out_valid(out_valid3), .out_data(out_data3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: who owns the output, where the round-robin search
  // resumes, and what the output register must hold.
  bit          m_busy, m_rr, m_ov, m_ol;
  int          m_grant, m_ptr, m_oc;
  logic [31:0] m_od;
  logic [3:0]  exp_rdy, acc_v;
  bit          nb, nrr;
  int          ng;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_rr = 0; m_ov = 0; m_ol = 0; m_od = '0; m_oc = 0;
      m_grant = 0; m_ptr = 3;
    end
    exp_rdy = (m_busy && (!m_ov || out_ready)) ? 4'(1 << m_grant) : 4'b0;
    check("m_out_valid", out_valid, m_ov);
    check("m_out_data", out_data, m_od);
    check("m_out_last", out_last, m_ol);
    check("m_out_ch", out_ch, 64'(m_oc));
    check("m_in_ready", in_ready, exp_rdy);
    if (rst_n) begin
      acc_v = in_valid & exp_rdy;
      nb = m_busy; ng = m_grant; nrr = m_rr;
      if (!m_busy) begin
        if (mode == 1'b0) begin
          if (in_valid[sel]) begin nb = 1; ng = int'(sel); nrr = 0; end
        end else begin
          for (int i = 4; i >= 1; i--) begin
            if (in_valid[2'((m_ptr + i) % 4)]) begin nb = 1; ng = (m_ptr + i) % 4; nrr = 1; end
          end
        end
      end else if (acc_v != 4'b0) begin
        m_ov = 1;
        m_od = in_data[7'(m_grant * 32) +: 32];
        m_ol = in_last[2'(m_grant)];
        m_oc = m_grant;
        if (in_last[2'(m_grant)]) begin
          nb = 0;
          if (m_rr) m_ptr = m_grant;
        end
      end
      if (acc_v == 4'b0 && out_ready) m_ov = 0;
      m_busy = nb; m_grant = ng; m_rr = nrr;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input bit v, input logic [31:0] d, input bit l);
    in_valid[2'(k)]        = v;
    in_data[7'(k*32) +: 32] = d;
    in_last[2'(k)]         = l;
  endtask

  // Present one beat and return just after the edge that accepts it.
  task automatic send_beat(input int k, input logic [31:0] d, input bit l);
    bit acc;
    int guard;
    set_ch(k, 1'b1, d, l);
    acc = 0;
    guard = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_valid[2'(k)] && in_ready[2'(k)];
      tick();
      guard++;
    end
    if (!acc) check("send_timeout", 64'(acc), 64'd1);
  endtask

  int         rem [4];
  logic [3:0] acc_s;
  int         q_ch[$];
  int         q_cyc[$];
  int         exp_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    rst_n = 0; mode = 0; sel = 0; in_valid = 0; in_data = 0; in_last = 0; out_ready = 1;
    mode3 = 0; sel3 = 0; in_valid3 = 0; in_data3 = 0; in_last3 = 0; out_ready3 = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1;

    // 1: sel mode, 3-beat packet on ch2
    mode = 0; sel = 2;
    set_ch(2, 1, 32'hA0A0_0001, 0);
    tick();
    check("t1_arb_no_out", out_valid, 0);
    check("t1_ready_ch2", in_ready, 4'b0100);
    tick();
    check("t1_a_valid", out_valid, 1);
    check("t1_a_data", out_data, 32'hA0A0_0001);
    check("t1_a_ch", out_ch, 2);
    check("t1_a_last", out_last, 0);
    set_ch(2, 1, 32'hB0B0_0002, 0);
    tick();
    check("t1_b_data", out_data, 32'hB0B0_0002);
    set_ch(2, 1, 32'hC0C0_0003, 1);
    tick();
    check("t1_c_data", out_data, 32'hC0C0_0003);
    check("t1_c_last", out_last, 1);
    set_ch(2, 0, 0, 0);
    tick();
    check("t1_drained", out_valid, 0);

    // 2: round-robin over four single-beat packets, ch0 sends twice
    mode = 1;
    rem = '{2, 1, 1, 1};
    for (int k = 0; k < 4; k++) set_ch(k, 1, 32'hB100 + k, 1);
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      acc_s = in_valid & in_ready;
      if (out_valid) begin
        q_ch.push_back(int'(out_ch));
        q_cyc.push_back(cyc);
      end
      tick();
      for (int k = 0; k < 4; k++) begin
        if (acc_s[k]) begin
          rem[k]--;
          if (rem[k] > 0) set_ch(k, 1, 32'hB200 + k, 1);
          else set_ch(k, 0, 0, 0);
        end
      end
    end
    check("t2_count", q_ch.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < q_ch.size()) check("t2_order", q_ch[i], exp_order[i]);
      if (i > 0 && i < q_cyc.size()) check("t2_gap", q_cyc[i] - q_cyc[i-1], 2);
    end

    // 3: stall with out_ready low for 5 cycles
    mode = 0; sel = 1;
    set_ch(1, 1, 32'hD000_0000, 0);
    tick();
    tick();
    check("t3_d0", out_data, 32'hD000_0000);
    out_ready = 0;
    set_ch(1, 1, 32'hD000_0001, 0);
    repeat (5) begin
      @(negedge clk);
      check("t3_hold_data", out_data, 32'hD000_0000);
      check("t3_ready_low", in_ready[1], 0);
      tick();
    end
    out_ready = 1;
    send_beat(1, 32'hD000_0001, 0);
    check("t3_d1", out_data, 32'hD000_0001);
    send_beat(1, 32'hD000_0002, 1);
    check("t3_d2", out_data, 32'hD000_0002);
    check("t3_d2_last", out_last, 1);
    set_ch(1, 0, 0, 0);

    // 4: ch3 requests while ch0 owns the output; sel change during BUSY ignored
    mode = 0; sel = 0;
    send_beat(0, 32'hE000_0000, 0);
    set_ch(0, 1, 32'hE000_0001, 0);
    set_ch(3, 1, 32'hF000_0003, 1);
    sel = 3;
    @(negedge clk);
    check("t4_ch3_blocked", in_ready[3], 0);
    tick();
    check("t4_e1", out_data, 32'hE000_0001);
    check("t4_e1_ch", out_ch, 0);
    send_beat(0, 32'hE000_0002, 1);
    set_ch(0, 0, 0, 0);
    check("t4_idle_ready", in_ready, 0);
    send_beat(3, 32'hF000_0003, 1);
    set_ch(3, 0, 0, 0);
    check("t4_f_data", out_data, 32'hF000_0003);
    check("t4_f_ch", out_ch, 3);

    // 5: N_CH=3 instance, sel=3 is out of range
    sel3 = 3; in_valid3 = 3'b111; in_data3 = 24'h332211; in_last3 = 3'b111;
    repeat (3) tick();
    check("t5_no_valid", out_valid3, 0);
    check("t5_no_ready", in_ready3, 0);
    sel3 = 2;
    tick();
    check("t5_grant2", in_ready3, 3'b100);
    tick();
    check("t5_data", out_data3, 8'h33);
    check("t5_ch", out_ch3, 2);
    in_valid3 = 0;

    // 6: async reset mid-packet, round-robin restarts at ch0
    mode = 1;
    set_ch(2, 1, 32'h6000_0000, 0);
    tick();
    tick();
    check("t6_pre", out_data, 32'h6000_0000);
    set_ch(2, 1, 32'h6000_0001, 0);
    #2;
    rst_n = 0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_data", out_data, 0);
    check("t6_rst_last", out_last, 0);
    check("t6_rst_ch", out_ch, 0);
    check("t6_rst_ready", in_ready, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int k = 0; k < 4; k++) set_ch(k, 1, 32'h7000_0000 + k, 1);
    tick();
    tick();
    in_valid = 0;
    check("t6_first_valid", out_valid, 1);
    check("t6_first_ch", out_ch, 0);
    check("t6_first_data", out_data, 32'h7000_0000);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
